// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of lamp phase order and per-phase dwell bounds
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   light      observed lamp code (00 RED, 01 GREEN, 10 YELLOW, 11 illegal)
//   chk_en     checking enable; low holds the monitor in IDLE
//   clr_err    clears err_sticky (and err_count when built)
//   err_seq    one-cycle pulse on an illegal transition or the illegal code
//   err_short  one-cycle pulse when a full phase ends before its minimum dwell
//   err_long   one-cycle pulse when a phase first exceeds its maximum dwell
//   err_sticky accumulated error flag
//   phase_cnt  dwell of the current phase in cycles
//   cycle_cnt  completed YELLOW->RED transitions, wrapping
//   err_count  saturating error total, built only with TRAFFIC_MON_ERRCNT_EN
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 20,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 5,
    parameter int RED_MIN    = 4,
    parameter int RED_MAX    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       light,
    input  logic             chk_en,
    input  logic             clr_err,
    output logic             err_seq,
    output logic             err_short,
    output logic             err_long,
    output logic             err_sticky,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [7:0]       err_count
);
    typedef enum logic [1:0] {IDLE, RED, GREEN, YELLOW} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d, in_st, succ;
    logic             partial_q, partial_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] min_v, max_v;
    logic             err_seq_q, err_seq_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             err_sticky_q, err_sticky_d;
    logic             any_err;

    always_comb begin
        in_st = light == 2'b01 ? GREEN : light == 2'b10 ? YELLOW : RED;
        succ  = state_q == RED ? GREEN : state_q == GREEN ? YELLOW : RED;
        min_v = state_q == RED ? CNT_W'(RED_MIN) : state_q == GREEN ? CNT_W'(GREEN_MIN) : CNT_W'(YELLOW_MIN);
        max_v = state_q == RED ? CNT_W'(RED_MAX) : state_q == GREEN ? CNT_W'(GREEN_MAX) : CNT_W'(YELLOW_MAX);
        state_d     = state_q;
        partial_d   = partial_q;
        bad_d       = 1'b0;
        phase_cnt_d = phase_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        err_seq_d   = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        if (!chk_en) begin
            state_d     = IDLE;
            phase_cnt_d = '0;
        end else if (light == 2'b11) begin
            // bad_q marks a run of illegal codes so only its first sample pulses
            err_seq_d   = !bad_q;
            bad_d       = 1'b1;
            state_d     = IDLE;
            phase_cnt_d = '0;
        end else if (state_q == IDLE) begin
            state_d     = in_st;
            partial_d   = 1'b1;
            phase_cnt_d = ONE;
        end else if (in_st == state_q) begin
            phase_cnt_d = &phase_cnt_q ? phase_cnt_q : phase_cnt_q + ONE;
            // the count passes MAX only once per phase, so this pulses once
            err_long_d  = phase_cnt_q == max_v && !(&phase_cnt_q);
        end else if (in_st == succ) begin
            err_short_d = !partial_q && phase_cnt_q < min_v;
            cycle_cnt_d = state_q == YELLOW ? cycle_cnt_q + ONE : cycle_cnt_q;
            state_d     = in_st;
            partial_d   = 1'b0;
            phase_cnt_d = ONE;
        end else begin
            err_seq_d   = 1'b1;
            state_d     = in_st;
            partial_d   = 1'b1;
            phase_cnt_d = ONE;
        end
        any_err      = err_seq_d | err_short_d | err_long_d;
        err_sticky_d = any_err | (err_sticky_q & !clr_err);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            partial_q    <= 1'b0;
            bad_q        <= 1'b0;
            phase_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            err_seq_q    <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            partial_q    <= partial_d;
            bad_q        <= bad_d;
            phase_cnt_q  <= phase_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            err_seq_q    <= err_seq_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef TRAFFIC_MON_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = clr_err ? {7'd0, any_err} : (any_err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

    assign err_seq    = err_seq_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign err_sticky = err_sticky_q;
    assign phase_cnt  = phase_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] light = 2'b00;
    logic       chk_en = 1'b1;
    logic       clr_err = 1'b0;
    logic       err_seq, err_short, err_long, err_sticky;
    logic [7:0] phase_cnt, cycle_cnt, err_count;

    traffic_light_monitor dut (
        .clk(clk), .reset(reset), .light(light), .chk_en(chk_en), .clr_err(clr_err),
        .err_seq(err_seq), .err_short(err_short), .err_long(err_long), .err_sticky(err_sticky),
        .phase_cnt(phase_cnt), .cycle_cnt(cycle_cnt), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       seq;
        logic       sht;
        logic       lng;
        logic       sticky;
        logic [7:0] pc;
        logic [7:0] cc;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   MINV[3] = '{4, 4, 2};
    int   MAXV[3] = '{20, 20, 5};
    int   m_prev = -1, m_dwell = 0, m_cyc = 0, m_ec = 0;
    bit   m_partial = 0, m_bad = 0, m_sticky = 0;
    int   pulses;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Model computes what the DUT must show after the coming edge, queues it, then compares.
    task automatic step(input logic [1:0] l, input logic en = 1'b1, input logic clr = 1'b0, input logic rst = 1'b1);
        exp_t e;
        bit   any;
        e = '0;
        if (!rst) begin
            m_prev = -1; m_dwell = 0; m_partial = 0; m_bad = 0; m_cyc = 0; m_sticky = 0; m_ec = 0;
        end else begin
            if (!en) begin
                m_prev = -1; m_dwell = 0; m_bad = 0;
            end else if (l == 2'b11) begin
                e.seq = !m_bad; m_bad = 1; m_prev = -1; m_dwell = 0;
            end else begin
                m_bad = 0;
                if (m_prev < 0) begin
                    m_prev = int'(l); m_dwell = 1; m_partial = 1;
                end else if (int'(l) == m_prev) begin
                    m_dwell++;
                    e.lng = (m_dwell == MAXV[l] + 1);
                end else if (int'(l) == (m_prev + 1) % 3) begin
                    e.sht = !m_partial && m_dwell < MINV[m_prev];
                    if (m_prev == 2) m_cyc++;
                    m_prev = int'(l); m_dwell = 1; m_partial = 0;
                end else begin
                    e.seq = 1; m_prev = int'(l); m_dwell = 1; m_partial = 1;
                end
            end
            any = e.seq | e.sht | e.lng;
            m_sticky = any | (m_sticky & !clr);
`ifdef TRAFFIC_MON_ERRCNT_EN
            m_ec = clr ? int'(any) : (any && m_ec < 255) ? m_ec + 1 : m_ec;
`endif
        end
        e.pc = 8'(m_dwell); e.cc = 8'(m_cyc % 256); e.sticky = m_sticky; e.ec = 8'(m_ec);
        exp_q.push_back(e);
        light = l; chk_en = en; clr_err = clr; reset = rst;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("err_seq", 8'(err_seq), 8'(e.seq));
        chk("err_short", 8'(err_short), 8'(e.sht));
        chk("err_long", 8'(err_long), 8'(e.lng));
        chk("err_sticky", 8'(err_sticky), 8'(e.sticky));
        chk("phase_cnt", phase_cnt, e.pc);
        chk("cycle_cnt", cycle_cnt, e.cc);
        chk("err_count", err_count, e.ec);
    endtask

    task automatic hold(input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    initial begin
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        chk("reset_phase_cnt", phase_cnt, 8'd0);
        chk("reset_sticky", 8'(err_sticky), 8'd0);
        // legal full cycle
        hold(2'b00, 6); hold(2'b01, 10); hold(2'b10, 3); hold(2'b00, 6);
        chk("legal_phase_cnt", phase_cnt, 8'd6);
        chk("legal_cycle_cnt", cycle_cnt, 8'd1);
        chk("legal_sticky", 8'(err_sticky), 8'd0);
        // short GREEN; clear raced against the err_short it causes
        hold(2'b01, 2);
        step(2'b10, 1'b1, 1'b1);
        chk("short_pulse", 8'(err_short), 8'd1);
        chk("race_sticky", 8'(err_sticky), 8'd1);
`ifdef TRAFFIC_MON_ERRCNT_EN
        chk("race_err_count", err_count, 8'd1);
`endif
        step(2'b10, 1'b1, 1'b1);
        chk("clear_sticky", 8'(err_sticky), 8'd0);
        step(2'b10);
        hold(2'b00, 6);
        // long GREEN: exactly one err_long
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step(2'b01);
            pulses += int'(err_long);
            if (phase_cnt == 8'd21) chk("long_at_21", 8'(err_long), 8'd1);
        end
        chk("long_pulses", 8'(pulses), 8'd1);
        // illegal order then illegal code
        step(2'b00);
        chk("green_red_seq", 8'(err_seq), 8'd1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(2'b11);
            pulses += int'(err_seq);
        end
        chk("code11_pulses", 8'(pulses), 8'd1);
        chk("code11_phase_cnt", phase_cnt, 8'd0);
        hold(2'b00, 2);
        step(2'b01);
        chk("partial_no_short", 8'(err_short), 8'd0);
        hold(2'b01, 6);
        chk("pre_reset_phase_cnt", phase_cnt, 8'd7);
        // reset mid-GREEN, then YELLOW starts as a partial phase
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk("midreset_sticky", 8'(err_sticky), 8'd0);
        chk("midreset_cycle_cnt", cycle_cnt, 8'd0);
        step(2'b10);
        chk("post_reset_no_seq", 8'(err_seq), 8'd0);
        chk("post_reset_phase_cnt", phase_cnt, 8'd1);
        hold(2'b10, 2);
        step(2'b00);
        chk("post_reset_cycle_cnt", cycle_cnt, 8'd1);
        // checking disabled
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0);
        chk("disabled_phase_cnt", phase_cnt, 8'd0);
        step(2'b01);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
